// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor (diff = a - b - borrow_in), LSB first, valid/ready on both sides.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_sub #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   input  logic               borrow_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [width_p-1:0] diff_o,
   output logic               borrow_o,
   output logic               overflow_o
);

   localparam int cnt_w = $clog2(width_p);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e             state_r, state_n;
   logic [width_p-1:0] a_sr, b_sr, res_sr;
   logic [cnt_w-1:0]   cnt_r;
   logic               br_r, d, br_n, last, accept;

   // single full-subtractor cell working on the current LSBs
   assign d      = a_sr[0] ^ b_sr[0] ^ br_r;
   assign br_n   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br_r);
   assign last   = (cnt_r == cnt_w'(width_p - 1));
   // ready_o is registered, so it also gates the first idle cycle after reset
   assign accept = (state_r == IDLE) & ready_o & valid_i;

   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE:    if (accept)  state_n = BUSY;
         BUSY:    if (last)    state_n = DONE;
         DONE:    if (ready_i) state_n = IDLE;
         default:              state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         ready_o <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         state_r <= state_n;
         ready_o <= (state_n == IDLE);
         valid_o <= (state_n == DONE);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         cnt_r    <= '0;
         br_r     <= 1'b0;
         diff_o   <= '0;
         borrow_o <= 1'b0;
      end else if (accept) begin
         a_sr  <= a_i;
         b_sr  <= b_i;
         br_r  <= borrow_i;
         cnt_r <= '0;
      end else if (state_r == BUSY) begin
         a_sr   <= {1'b0, a_sr[width_p-1:1]};
         b_sr   <= {1'b0, b_sr[width_p-1:1]};
         res_sr <= {d, res_sr[width_p-1:1]};
         br_r   <= br_n;
         cnt_r  <= cnt_r + 1'b1;
         // visible outputs only change when the whole word is complete
         if (last) begin
            diff_o   <= {d, res_sr[width_p-1:1]};
            borrow_o <= br_n;
         end
      end
   end

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic a_msb_r, b_msb_r;

   // d on the last BUSY edge is the result MSB
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         a_msb_r    <= 1'b0;
         b_msb_r    <= 1'b0;
         overflow_o <= 1'b0;
      end else if (accept) begin
         a_msb_r <= a_i[width_p-1];
         b_msb_r <= b_i[width_p-1];
      end else if (state_r == BUSY && last) begin
         overflow_o <= (a_msb_r != b_msb_r) && (d != a_msb_r);
      end
   end
`else
   assign overflow_o = 1'b0;
`endif

endmodule
